// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshake: 1-cycle ops, shift-add MUL, registered result/flags {C,V,N,Z}.
// Define SEQ_ALU_MUL_EN to build the multi-cycle multiplier; otherwise op 111 completes at once as illegal.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             out_valid_q;
    logic [WIDTH+1:0] alu_res_w;

`ifdef SEQ_ALU_MUL_EN
    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
`endif

    // Returns {C, V, result}; op 111 lands in the default arm as the illegal encoding.
    function automatic logic [WIDTH+1:0] alu_op(input logic [2:0] opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic [SHW-1:0]   amt;
        ext = '0;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        amt = b[SHW-1:0];
        case (opc)
            3'b000: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: begin
                // Extra guard bit catches the last bit shifted out.
                ext = {1'b0, a} << amt;
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
            end
            3'b110: begin
                ext = {a, 1'b0} >> amt;
                r   = ext[WIDTH:1];
                c   = ext[0];
            end
            default: v = 1'b1;
        endcase
        return {c, v, r};
    endfunction

    function automatic logic [3:0] pack_flags(input logic c, input logic v,
                                              input logic [WIDTH-1:0] r);
        return {c, v, r[WIDTH-1], (r == '0)};
    endfunction

    assign alu_res_w = alu_op(op, operand1, operand2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_ALU_MUL_EN
                        if (op == 3'b111) begin
                            acc_q    <= '0;
                            mcand_q  <= {{WIDTH{1'b0}}, operand1};
                            mplier_q <= operand2;
                            cnt_q    <= '0;
                            state_q  <= EXEC;
                        end else
`endif
                        begin
                            result_q    <= alu_res_w[WIDTH-1:0];
                            flags_q     <= pack_flags(alu_res_w[WIDTH+1], alu_res_w[WIDTH],
                                                      alu_res_w[WIDTH-1:0]);
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                EXEC: begin
`ifdef SEQ_ALU_MUL_EN
                    // WIDTH accumulate steps, then one extra cycle to publish the product.
                    if (cnt_q == CNT_LAST) begin
                        result_q    <= acc_q[WIDTH-1:0];
                        flags_q     <= pack_flags(1'b0, |acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:0]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CW'(1);
                    end
`else
                    state_q <= IDLE;
`endif
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8); MUL scenarios follow SEQ_ALU_MUL_EN.
module tb_seq_alu;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
    } vec_t;

    vec_t vecs [11] = '{
        '{3'b001, 8'h05, 8'h07, 8'hFE, 4'b1010},
        '{3'b101, 8'h81, 8'h09, 8'h02, 4'b1000},
        '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1001},
        '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b0100},
        '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1101},
        '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000},
        '{3'b011, 8'h00, 8'h00, 8'h00, 4'b0001},
        '{3'b100, 8'h0F, 8'hF0, 8'hFF, 4'b0010},
        '{3'b110, 8'h03, 8'h02, 8'h00, 4'b1001},
        '{3'b101, 8'h81, 8'hF8, 8'h81, 4'b0010},
        '{3'b110, 8'h81, 8'h07, 8'h01, 4'b0000}
    };

    seq_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .operand1 (operand1),
        .operand2 (operand2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .flags    (flags)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        in_valid  = 1'b1;
        op        = 3'b000;
        operand1  = 8'h02;
        operand2  = 8'h03;
        out_ready = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b result=%h flags=%b required 0/00/0000",
                     out_valid, result, flags);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL accept_in_reset: out_valid=%b required 0", out_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h05 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL first_accept: out_valid=%b result=%h flags=%b required 1/05/0000",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive_req(3'b000, 8'h7F, 8'h01);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h80 || flags !== 4'b0110) begin
            failures++;
            $display("FAIL add_overflow: out_valid=%b result=%h flags=%b required 1/80/0110",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_ops();
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive_req(vecs[i].op, vecs[i].a, vecs[i].b);
            checks++;
            if (out_valid !== 1'b1 || result !== vecs[i].r || flags !== vecs[i].f) begin
                failures++;
                $display("FAIL op_vec%0d: op=%b a=%h b=%h got v=%b r=%h f=%b required 1/%h/%b",
                         i, vecs[i].op, vecs[i].a, vecs[i].b, out_valid, result, flags,
                         vecs[i].r, vecs[i].f);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'b000;
        operand1  = 8'h01;
        operand2  = 8'h01;
        @(posedge clk); #1;
        operand1 = 8'h03;
        operand2 = 8'h04;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h02) begin
            failures++;
            $display("FAIL b2b_first: out_valid=%b result=%h required 1/02", out_valid, result);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 8'h02) begin
            failures++;
            $display("FAIL b2b_gap: out_valid=%b in_ready=%b result=%h required 0/1/02",
                     out_valid, in_ready, result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h07 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_second: out_valid=%b result=%h flags=%b required 1/07/0000",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        out_ready = 1'b0;
        drive_req(3'b100, 8'hAA, 8'hAA);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h00 || flags !== 4'b0001) begin
            failures++;
            $display("FAIL hold_first: out_valid=%b result=%h flags=%b required 1/00/0001",
                     out_valid, result, flags);
        end
        in_valid = 1'b1;
        op       = 3'b000;
        operand1 = 8'h01;
        operand2 = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 8'h00 || flags !== 4'b0001 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d: v=%b r=%h f=%b rdy=%b required 1/00/0001/0",
                         i, out_valid, result, flags, in_ready);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
    endtask

`ifdef SEQ_ALU_MUL_EN
    task automatic test_mul();
        int  n;
        logic seen;
        out_ready = 1'b1;
        drive_req(3'b111, 8'h10, 8'h10);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != 0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mul_busy: bad_cycles=%0d in_ready=%b required 0/0", n, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h00 || flags !== 4'b0101) begin
            failures++;
            $display("FAIL mul_10x10: out_valid=%b result=%h flags=%b required 1/00/0101 at t+9",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
        drive_req(3'b111, 8'h0C, 8'h0B);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            seen = out_valid;
        end
        checks++;
        if (!seen || result !== 8'h84 || flags !== 4'b0010) begin
            failures++;
            $display("FAIL mul_0Cx0B: seen=%b result=%h flags=%b required 1/84/0010",
                     seen, result, flags);
        end
        @(posedge clk); #1;
        drive_req(3'b111, 8'hFF, 8'hFF);
        repeat (9) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h01 || flags !== 4'b0100) begin
            failures++;
            $display("FAIL mul_FFxFF: out_valid=%b result=%h flags=%b required 1/01/0100",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask
`else
    task automatic test_mul_disabled();
        out_ready = 1'b1;
        drive_req(3'b111, 8'h03, 8'h04);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h00 || flags !== 4'b0101) begin
            failures++;
            $display("FAIL mul_illegal: out_valid=%b result=%h flags=%b required 1/00/0101",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_abort();
        int pulses;
        out_ready = 1'b0;
        drive_req(3'b000, 8'h01, 8'h02);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0) begin
            failures++;
            $display("FAIL abort_done: out_valid=%b result=%h flags=%b required 0/00/0000",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
`ifdef SEQ_ALU_MUL_EN
        drive_req(3'b111, 8'h0C, 8'h0B);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 8'h00 || flags !== 4'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_exec: v=%b r=%h f=%b rdy=%b required 0/00/0000/1",
                     out_valid, result, flags, in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
`endif
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_pulse: out_valid high for %0d cycles required 0", pulses);
        end
        drive_req(3'b000, 8'h01, 8'h01);
        checks++;
        if (out_valid !== 1'b1 || result !== 8'h02 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL abort_next_add: out_valid=%b result=%h flags=%b required 1/02/0000",
                     out_valid, result, flags);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ops();
        test_back_to_back();
        test_hold();
`ifdef SEQ_ALU_MUL_EN
        test_mul();
`else
        test_mul_disabled();
`endif
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits, legal range 4..32.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  block can accept a request.
REQ-006 SHALL have port: op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
REQ-007 SHALL have port: operand1  input  WIDTH  first operand.
REQ-008 SHALL have port: operand2  input  WIDTH  second operand, or shift amount for SHL/SHR.
REQ-009 SHALL have port: out_valid  output  1  result and flags valid.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: result  output  WIDTH  registered result.
REQ-012 SHALL have port: flags  output  4  registered {C,V,N,Z}, bit3=C, bit0=Z.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a request when in_valid && in_ready at a rising edge, capturing op/operands.
REQ-015 Non-MUL op accepted at edge t: SHALL be IDLE->DONE, out_valid=1 after edge t (1-cycle latency).
REQ-016 MUL accepted: SHALL be IDLE->EXEC, shift-add one operand bit per cycle for WIDTH cycles, then EXEC->DONE; out_valid=1 after edge t+WIDTH+1.
REQ-017 In DONE, SHALL hold result/flags stable while out_ready=0; on out_valid && out_ready SHALL go DONE->IDLE, out_valid=0 next cycle.
REQ-018 No new request SHALL be accepted in EXEC or DONE (no overlap); in_valid there is ignored.
REQ-019 ADD/SUB SHALL be modulo 2^WIDTH; C = carry-out for ADD, borrow (operand1<operand2 unsigned) for SUB; V = two's-complement overflow.
REQ-020 AND/OR/XOR SHALL set C=0, V=0.
REQ-021 SHL/SHR SHALL shift by operand2[clog2(WIDTH)-1:0] (upper bits ignored), zero fill, C=last bit shifted out (0 for amount 0), V=0.
REQ-022 MUL SHALL be unsigned; result = low WIDTH bits of product; V=1 iff high WIDTH bits nonzero; C=0.
REQ-023 For all ops N=result[WIDTH-1], Z=(result==0).

Reset
REQ-024 reset=0 SHALL force state IDLE, result=0, flags=0, out_valid=0; in_ready=1 once reset=1.
REQ-025 reset asserted mid-EXEC or in DONE SHALL abandon the operation with no out_valid pulse.
REQ-026 First accept after release SHALL occur no earlier than first rising edge with reset=1.

Configuration
REQ-027 Macro SEQ_ALU_MUL_EN defined: MUL per REQ-016/REQ-022.
REQ-028 SEQ_ALU_MUL_EN undefined: no multiplier/EXEC logic; op 111 SHALL complete in 1 cycle as illegal, result=0, flags=4'b0101 (V=1 marks illegal, Z=1).

Verification (WIDTH=8)
REQ-029 ADD 8'h7F+8'h01, out_ready=1 -> out_valid next cycle, result 8'h80, flags 4'b0110.
REQ-030 SUB 8'h05-8'h07 -> result 8'hFE, flags 4'b1010; SHL 8'h81 by 8'h09 (amount 1) -> 8'h02, flags 4'b1000.
REQ-031 MUL 8'h10*8'h10 with SEQ_ALU_MUL_EN -> in_ready=0 for 9 cycles, out_valid at edge t+9, result 8'h00, flags 4'b0101; 8'h0C*8'h0B -> 8'h84, flags 4'b0010.
REQ-032 XOR 8'hAA^8'hAA with out_ready=0 for 5 cycles -> result 8'h00, flags 4'b0001 held stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-033 reset=0 pulsed between clock edges 4 cycles into MUL -> out_valid, result, flags 0 immediately, no out_valid pulse; next ADD 8'h01+8'h01 -> 8'h02.
REQ-034 SEQ_ALU_MUL_EN undefined, MUL 8'h03*8'h04 -> out_valid next cycle, result 8'h00, flags 4'b0101.
